// File: rtl/ars_rk_reverse_buf_if.sv
// Round-key buffer port bundle: write side from key expansion, replay side to the round function.
interface ars_rk_reverse_buf_if #(
    parameter int BWIDTH = 32,
    parameter int NRK    = 32
);
    localparam int AW = $clog2(NRK);

    logic              clr;
    logic              wr_en;
    logic [BWIDTH-1:0] wr_rk;
    logic              rd_start;
    logic              rd_mode;
    logic              rd_ready;
    logic              rd_valid;
    logic [BWIDTH-1:0] rd_rk;
    logic [AW-1:0]     rd_idx;
    logic              full;
    logic              busy;
    logic              wr_err;

    modport master (
        output clr, wr_en, wr_rk, rd_start, rd_mode, rd_ready,
        input  rd_valid, rd_rk, rd_idx, full, busy, wr_err
    );

    modport slave (
        input  clr, wr_en, wr_rk, rd_start, rd_mode, rd_ready,
        output rd_valid, rd_rk, rd_idx, full, busy, wr_err
    );
endinterface

// File: rtl/ars_rk_reverse_buf.sv
// SMS4 round-key buffer: loads rk0..rk(NRK-1) in order, replays forward (encrypt) or reverse (decrypt).
module ars_rk_reverse_buf #(
    parameter int BWIDTH = 32,
    parameter int NRK    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ars_rk_reverse_buf_if.slave  bus
);
    localparam int AW = $clog2(NRK);

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_FULL, S_READ} state_e;

    state_e            state_q, state_d;
    logic [AW:0]       wcnt_q, wcnt_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]     rnd_q, rnd_d;
    logic              mode_q, mode_d;
    logic              wr_err_q, wr_err_d;
    logic [BWIDTH-1:0] rd_rk_q, rd_rk_d;
    logic [BWIDTH-1:0] mem_q [NRK];
    logic              mem_we;
    logic [AW-1:0]     ptr_start, ptr_step;

    always_comb begin
        ptr_start = bus.rd_mode ? AW'(NRK - 1) : '0;
        ptr_step  = mode_q ? ptr_q - AW'(1) : ptr_q + AW'(1);
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        ptr_d    = ptr_q;
        rnd_d    = rnd_q;
        mode_d   = mode_q;
        wr_err_d = wr_err_q;
        rd_rk_d  = rd_rk_q;
        mem_we   = 1'b0;
        if (bus.clr) begin
            state_d  = S_EMPTY;
            wcnt_d   = '0;
            ptr_d    = '0;
            rnd_d    = '0;
            wr_err_d = 1'b0;
        end else begin
            case (state_q)
                S_EMPTY, S_LOAD: begin
                    if (bus.wr_en) begin
                        mem_we  = 1'b1;
                        wcnt_d  = wcnt_q + (AW+1)'(1);
                        state_d = (wcnt_d == (AW+1)'(NRK)) ? S_FULL : S_LOAD;
                    end
                end
                S_FULL: begin
                    if (bus.wr_en) wr_err_d = 1'b1;
                    if (bus.rd_start) begin
                        mode_d  = bus.rd_mode;
                        ptr_d   = ptr_start;
                        rnd_d   = '0;
                        rd_rk_d = mem_q[ptr_start];
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    if (bus.wr_en) wr_err_d = 1'b1;
                    if (bus.rd_ready) begin
                        // rd_rk is registered, so preload the word for the next round here
                        ptr_d   = ptr_step;
                        rnd_d   = rnd_q + AW'(1);
                        rd_rk_d = mem_q[ptr_step];
                        if (rnd_q == AW'(NRK - 1)) state_d = S_FULL;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_EMPTY;
            wcnt_q   <= '0;
            ptr_q    <= '0;
            rnd_q    <= '0;
            mode_q   <= 1'b0;
            wr_err_q <= 1'b0;
            rd_rk_q  <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            ptr_q    <= ptr_d;
            rnd_q    <= rnd_d;
            mode_q   <= mode_d;
            wr_err_q <= wr_err_d;
            rd_rk_q  <= rd_rk_d;
        end
    end

    // Key storage is deliberately not reset; validity is tracked by wcnt/state.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wcnt_q[AW-1:0]] <= bus.wr_rk;
    end

    assign bus.rd_valid = (state_q == S_READ);
    assign bus.busy     = (state_q == S_READ);
    assign bus.full     = (state_q == S_FULL);
    assign bus.rd_rk    = rd_rk_q;
    assign bus.rd_idx   = rnd_q;
    assign bus.wr_err   = wr_err_q;
endmodule

// File: tb/tb_ars_rk_reverse_buf.sv
// Directed bench for ars_rk_reverse_buf: load, forward/reverse replay, stalls, drops, clr and reset.
module tb_ars_rk_reverse_buf;
    localparam int BW  = 32;
    localparam int NRK = 32;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    ars_rk_reverse_buf_if #(.BWIDTH(BW), .NRK(NRK)) bus ();

    ars_rk_reverse_buf #(.BWIDTH(BW), .NRK(NRK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, ".rd_valid"}, 64'(bus.rd_valid), 64'd0);
        chk({tag, ".rd_rk"},    64'(bus.rd_rk),    64'd0);
        chk({tag, ".rd_idx"},   64'(bus.rd_idx),   64'd0);
        chk({tag, ".full"},     64'(bus.full),     64'd0);
        chk({tag, ".busy"},     64'(bus.busy),     64'd0);
        chk({tag, ".wr_err"},   64'(bus.wr_err),   64'd0);
    endtask

    task automatic load(input logic [31:0] base, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_rk = base + 32'(i);
            if (i == NRK - 1) chk("full_before_last", 64'(bus.full), 64'd0);
            step();
        end
        bus.wr_en = 1'b0;
        if (hi == NRK - 1) chk("full_after_load", 64'(bus.full), 64'd1);
    endtask

    // junk: 0 none, 1 write alongside rd_start, 2 write during round 0.
    // abort_at >= 0: clr (abort_rst=0) or rst_n (abort_rst=1) in that round.
    task automatic replay(input bit mode, input logic [31:0] base, input int stall_at,
                          input int abort_at, input bit abort_rst, input int junk);
        logic [31:0] exp;
        bus.rd_start = 1'b1;
        bus.rd_mode  = mode;
        bus.rd_ready = 1'b1;
        if (junk == 1) begin bus.wr_en = 1'b1; bus.wr_rk = 32'hDEAD_BEEF; end
        step();
        bus.rd_start = 1'b0;
        bus.rd_mode  = 1'b0;
        bus.wr_en    = 1'b0;
        for (int k = 0; k < NRK; k++) begin
            exp = mode ? base + 32'(NRK - 1 - k) : base + 32'(k);
            if (k == abort_at) begin
                if (!abort_rst) begin
                    bus.clr = 1'b1;
                    step();
                    bus.clr = 1'b0;
                    chk("clr.rd_valid", 64'(bus.rd_valid), 64'd0);
                    chk("clr.busy",     64'(bus.busy),     64'd0);
                    chk("clr.full",     64'(bus.full),     64'd0);
                    chk("clr.wr_err",   64'(bus.wr_err),   64'd0);
                end else begin
                    rst_n = 1'b0;
                    #1;
                    chk_idle_reset("async_rst");
                    step();
                    rst_n = 1'b1;
                end
                return;
            end
            if (junk == 2 && k == 0) begin bus.wr_en = 1'b1; bus.wr_rk = 32'hBAD0_0BAD; end
            if (k == stall_at) begin
                bus.rd_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk("stall.rd_valid", 64'(bus.rd_valid), 64'd1);
                    chk("stall.rd_rk",    64'(bus.rd_rk),    64'(exp));
                    chk("stall.rd_idx",   64'(bus.rd_idx),   64'(k));
                    step();
                end
                bus.rd_ready = 1'b1;
            end
            chk("rd_valid", 64'(bus.rd_valid), 64'd1);
            chk("rd_rk",    64'(bus.rd_rk),    64'(exp));
            chk("rd_idx",   64'(bus.rd_idx),   64'(k));
            chk("busy",     64'(bus.busy),     64'd1);
            chk("full_rd",  64'(bus.full),     64'd0);
            step();
            bus.wr_en = 1'b0;
        end
        chk("end.rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("end.busy",     64'(bus.busy),     64'd0);
        chk("end.full",     64'(bus.full),     64'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.clr      = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_rk    = '0;
        bus.rd_start = 1'b0;
        bus.rd_mode  = 1'b0;
        bus.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_reset("reset");
        rst_n = 1'b1;
        step();

        // forward, then back-to-back reverse, then reverse with a stall at round 5
        load(32'h0100_0000, 0, NRK - 1);
        replay(1'b0, 32'h0100_0000, -1, -1, 1'b0, 0);
        replay(1'b1, 32'h0100_0000, -1, -1, 1'b0, 0);
        replay(1'b1, 32'h0100_0000, 5, -1, 1'b0, 0);

        // illegal requests
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk("clr_idle.full", 64'(bus.full), 64'd0);
        load(32'h0200_0000, 0, 9);
        bus.rd_start = 1'b1;
        step();
        bus.rd_start = 1'b0;
        chk("early_start.busy", 64'(bus.busy), 64'd0);
        chk("early_start.full", 64'(bus.full), 64'd0);
        load(32'h0200_0000, 10, NRK - 1);
        chk("wr_err_pre", 64'(bus.wr_err), 64'd0);
        bus.wr_en = 1'b1;
        bus.wr_rk = 32'hFFFF_0000;
        step();
        bus.wr_en = 1'b0;
        chk("wr_err_33rd", 64'(bus.wr_err), 64'd1);
        chk("full_33rd",   64'(bus.full),   64'd1);
        replay(1'b0, 32'h0200_0000, -1, -1, 1'b0, 2);
        chk("wr_err_sticky", 64'(bus.wr_err), 64'd1);
        replay(1'b1, 32'h0200_0000, -1, -1, 1'b0, 1);
        chk("wr_err_sticky2", 64'(bus.wr_err), 64'd1);

        // clr at round 12, reload, replay
        replay(1'b0, 32'h0200_0000, -1, 12, 1'b0, 0);
        load(32'h0300_0000, 0, NRK - 1);
        replay(1'b1, 32'h0300_0000, -1, -1, 1'b0, 0);

        // rst_n at round 20, reload, replay
        replay(1'b0, 32'h0300_0000, -1, 20, 1'b1, 0);
        load(32'h0400_0000, 0, NRK - 1);
        replay(1'b0, 32'h0400_0000, -1, -1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
